// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and tap table for the XNOR Fibonacci LFSR engine.
//   LFSR_MIN_BITS / LFSR_MAX_BITS : legal register width range.
//   lfsr_taps(n)                  : 32-bit tap mask for an n-bit maximal-length
//                                   XNOR LFSR; bit k-1 set means tap k is used.
package lfsr_pkg;

  localparam int LFSR_MIN_BITS = 3;
  localparam int LFSR_MAX_BITS = 32;

  // Maximal-length XNOR tap sets (1-indexed taps, stored at bit tap-1).
  function automatic logic [31:0] lfsr_taps(input int n);
    logic [31:0] mask_s;
    mask_s = 32'h0000_0000;
    case (n)
      3:       mask_s = 32'h0000_0006; // 3,2
      4:       mask_s = 32'h0000_000C; // 4,3
      5:       mask_s = 32'h0000_0014; // 5,3
      6:       mask_s = 32'h0000_0030; // 6,5
      7:       mask_s = 32'h0000_0060; // 7,6
      8:       mask_s = 32'h0000_00B8; // 8,6,5,4
      9:       mask_s = 32'h0000_0110; // 9,5
      10:      mask_s = 32'h0000_0240; // 10,7
      11:      mask_s = 32'h0000_0500; // 11,9
      12:      mask_s = 32'h0000_0829; // 12,6,4,1
      13:      mask_s = 32'h0000_100D; // 13,4,3,1
      14:      mask_s = 32'h0000_2015; // 14,5,3,1
      15:      mask_s = 32'h0000_6000; // 15,14
      16:      mask_s = 32'h0000_D008; // 16,15,13,4
      17:      mask_s = 32'h0001_2000; // 17,14
      18:      mask_s = 32'h0002_0400; // 18,11
      19:      mask_s = 32'h0004_0023; // 19,6,2,1
      20:      mask_s = 32'h0009_0000; // 20,17
      21:      mask_s = 32'h0014_0000; // 21,19
      22:      mask_s = 32'h0030_0000; // 22,21
      23:      mask_s = 32'h0042_0000; // 23,18
      24:      mask_s = 32'h00E1_0000; // 24,23,22,17
      25:      mask_s = 32'h0120_0000; // 25,22
      26:      mask_s = 32'h0200_0023; // 26,6,2,1
      27:      mask_s = 32'h0400_0013; // 27,5,2,1
      28:      mask_s = 32'h0900_0000; // 28,25
      29:      mask_s = 32'h1400_0000; // 29,27
      30:      mask_s = 32'h2000_0029; // 30,6,4,1
      31:      mask_s = 32'h4800_0000; // 31,28
      32:      mask_s = 32'h8020_0003; // 32,22,2,1
      default: mask_s = 32'h0000_0000;
    endcase
    return mask_s;
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// lfsr_feedback: combinational XNOR feedback for an NUM_BITS-wide Fibonacci LFSR.
//   state : current LFSR state (bit 0 is tap 1)
//   fb    : XNOR of the tapped state bits
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic [NUM_BITS-1:0] state,
  output logic                fb
);

  localparam logic [31:0] TAPS = lfsr_taps(NUM_BITS);

  // Untapped bits are masked to zero and do not change the parity.
  assign fb = ~^(state & TAPS[NUM_BITS-1:0]);

endmodule

// File: rtl/lfsr_engine.sv
// lfsr_engine: XNOR Fibonacci LFSR with clock enable, seed load with
// lock-up filtering and a registered end-of-sequence pulse.
// Optional macro LFSR_PERIOD_CHECK_EN builds a step counter that flags
// sequences whose period is not 2^NUM_BITS-1.
//   i_Clk        : clock, rising edge
//   i_Reset      : asynchronous active-high reset
//   i_Enable     : advance one step
//   i_Seed_DV    : load i_Seed_Data (wins over i_Enable)
//   i_Seed_Data  : new state / sequence start point
//   o_LFSR_Data  : current state
//   o_LFSR_Done  : one-cycle pulse, sequence returned to start point
//   o_Seed_Err   : one-cycle pulse, all-ones seed replaced by zero
//   o_Period_Err : one-cycle pulse, period check failed (0 without macro)
module lfsr_engine
  import lfsr_pkg::*;
#(
  parameter int                     NUM_BITS  = 8,
  parameter logic [NUM_BITS-1:0]    INIT_SEED = {NUM_BITS{1'b0}}
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done,
  output logic                o_Seed_Err,
  output logic                o_Period_Err
);

  if ((NUM_BITS < LFSR_MIN_BITS) || (NUM_BITS > LFSR_MAX_BITS)) begin : g_bad_width
    $error("lfsr_engine: NUM_BITS out of range");
  end
  if (&INIT_SEED) begin : g_bad_seed
    $error("lfsr_engine: INIT_SEED must not be all ones");
  end

  logic [NUM_BITS-1:0] lfsr_r;
  logic [NUM_BITS-1:0] start_r;
  logic                done_r;
  logic                seed_err_r;
  logic                fb_s;
  logic [NUM_BITS-1:0] adv_s;
  logic [NUM_BITS-1:0] seed_s;
  logic                seed_bad_s;
  logic                done_evt_s;
  logic                step_s;

  lfsr_feedback #(.NUM_BITS(NUM_BITS)) u_feedback (
    .state (lfsr_r),
    .fb    (fb_s)
  );

  // Next-step value, seed filtering and done detection.
  always_comb begin
    adv_s      = {lfsr_r[NUM_BITS-2:0], fb_s};
    seed_bad_s = &i_Seed_Data;
    step_s     = 1'b0;
    if (i_Seed_DV) begin
      step_s = 1'b0;
    end else begin
      step_s = i_Enable;
    end
    // All ones is the XNOR lock-up state; substitute zero.
    if (seed_bad_s) begin
      seed_s = {NUM_BITS{1'b0}};
    end else begin
      seed_s = i_Seed_Data;
    end
    done_evt_s = step_s && (adv_s == start_r);
  end

  // State, start point and pulse registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      lfsr_r     <= INIT_SEED;
      start_r    <= INIT_SEED;
      done_r     <= 1'b0;
      seed_err_r <= 1'b0;
    end else if (i_Seed_DV) begin
      lfsr_r     <= seed_s;
      start_r    <= seed_s;
      done_r     <= 1'b0;
      seed_err_r <= seed_bad_s;
    end else if (step_s) begin
      lfsr_r     <= adv_s;
      done_r     <= done_evt_s;
      seed_err_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      seed_err_r <= 1'b0;
    end
  end

`ifdef LFSR_PERIOD_CHECK_EN
  localparam logic [NUM_BITS-1:0] PERIOD = {NUM_BITS{1'b1}};

  logic [NUM_BITS-1:0] cnt_r;
  logic [NUM_BITS-1:0] cnt_inc_s;
  logic [NUM_BITS-1:0] cnt_nxt_s;
  logic                perr_nxt_s;
  logic                period_err_r;

  // Step counter update; it restarts after every done or error.
  always_comb begin
    cnt_inc_s  = cnt_r + {{(NUM_BITS-1){1'b0}}, 1'b1};
    cnt_nxt_s  = cnt_r;
    perr_nxt_s = 1'b0;
    if (i_Seed_DV) begin
      cnt_nxt_s = {NUM_BITS{1'b0}};
    end else if (step_s) begin
      if (done_evt_s) begin
        perr_nxt_s = (cnt_inc_s != PERIOD);
        cnt_nxt_s  = {NUM_BITS{1'b0}};
      end else if (cnt_inc_s == PERIOD) begin
        perr_nxt_s = 1'b1;
        cnt_nxt_s  = {NUM_BITS{1'b0}};
      end else begin
        cnt_nxt_s = cnt_inc_s;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Step counter and period error pulse registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_r        <= {NUM_BITS{1'b0}};
      period_err_r <= 1'b0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      period_err_r <= perr_nxt_s;
    end
  end

  assign o_Period_Err = period_err_r;
`else
  assign o_Period_Err = 1'b0;
`endif

  assign o_LFSR_Data = lfsr_r;
  assign o_LFSR_Done = done_r;
  assign o_Seed_Err  = seed_err_r;

endmodule

// File: tb/tb_lfsr_engine.sv
// tb_lfsr_engine: directed self-checking bench for lfsr_engine.
// A 4-bit instance walks the hand-derived sequence; an 8-bit instance checks
// the full 255-step period and a mid-sequence reload.
module tb_lfsr_engine;

  logic       clk;
  logic       rst;
  logic       en4, dv4;
  logic [3:0] seed4;
  logic [3:0] data4;
  logic       done4, serr4, perr4;
  logic       en8, dv8;
  logic [7:0] seed8;
  logic [7:0] data8;
  logic       done8, serr8, perr8;

  int n_cmp;
  int n_bad;

  logic [3:0] seq4 [0:14];
  logic [7:0] seq8 [0:4];

  lfsr_engine #(.NUM_BITS(4), .INIT_SEED(4'h0)) u_dut4 (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en4), .i_Seed_DV(dv4),
    .i_Seed_Data(seed4), .o_LFSR_Data(data4), .o_LFSR_Done(done4),
    .o_Seed_Err(serr4), .o_Period_Err(perr4)
  );

  lfsr_engine #(.NUM_BITS(8), .INIT_SEED(8'h00)) u_dut8 (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en8), .i_Seed_DV(dv8),
    .i_Seed_Data(seed8), .o_LFSR_Data(data8), .o_LFSR_Done(done8),
    .o_Seed_Err(serr8), .o_Period_Err(perr8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the 4-bit instance n steps from table index start_idx,
  // which is also the loaded start point.
  task automatic run4(input int start_idx, input int n);
    en4 = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      check("seq4_data", {28'h0, data4}, {28'h0, seq4[(start_idx + k) % 15]});
      check("seq4_done", {31'h0, done4}, {31'h0, (k % 15) == 0});
      check("seq4_perr", {31'h0, perr4}, 32'h0);
    end
    en4 = 1'b0;
  endtask

  // Advance the 8-bit instance until done; returns the step count.
  task automatic count8(output int steps, output logic perr_seen);
    logic got;
    got       = 1'b0;
    perr_seen = 1'b0;
    steps     = 0;
    en8       = 1'b1;
    while (!got && steps < 400) begin
      tick();
      steps++;
      if (perr8) perr_seen = 1'b1;
      if (done8) got = 1'b1;
    end
    en8 = 1'b0;
  endtask

  initial begin
    int         adv;
    int         steps;
    logic       perr_seen;
    logic       en_q;

    n_cmp = 0;
    n_bad = 0;
    seq4 = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
             4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
    seq8 = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    rst = 1'b1; en4 = 1'b0; dv4 = 1'b0; seed4 = 4'h0;
    en8 = 1'b0; dv8 = 1'b0; seed8 = 8'h00;
    #12;
    check("rst_data", {28'h0, data4}, 32'h0);
    check("rst_done", {31'h0, done4}, 32'h0);
    check("rst_serr", {31'h0, serr4}, 32'h0);
    check("rst_perr", {31'h0, perr4}, 32'h0);
    rst = 1'b0;
    tick();

    // Continuous enable: two full periods, done at advances 15 and 30.
    run4(0, 30);

    // Enable toggling: same sequence at half rate.
    adv = 0;
    for (int c = 1; c <= 30; c++) begin
      en4  = c[0];
      en_q = c[0];
      tick();
      if (en_q) adv++;
      check("tog_data", {28'h0, data4}, {28'h0, seq4[adv % 15]});
      check("tog_done", {31'h0, done4}, {31'h0, en_q && (adv % 15 == 0)});
    end
    en4 = 1'b0;

    // Seed 5 load, then a full period back to 5.
    dv4 = 1'b1; seed4 = 4'h5;
    tick();
    dv4 = 1'b0;
    check("ld5_data", {28'h0, data4}, 32'h5);
    check("ld5_done", {31'h0, done4}, 32'h0);
    check("ld5_serr", {31'h0, serr4}, 32'h0);
    run4(11, 15);

    // All-ones seed: zero loaded, error pulse for one cycle.
    dv4 = 1'b1; seed4 = 4'hF;
    tick();
    dv4 = 1'b0;
    check("ldF_data", {28'h0, data4}, 32'h0);
    check("ldF_serr", {31'h0, serr4}, 32'h1);
    tick();
    check("ldF_serr_clr", {31'h0, serr4}, 32'h0);
    run4(0, 15);

    // Load and enable together: load wins.
    dv4 = 1'b1; en4 = 1'b1; seed4 = 4'h3;
    tick();
    dv4 = 1'b0; en4 = 1'b0;
    check("both_data", {28'h0, data4}, 32'h3);
    check("both_done", {31'h0, done4}, 32'h0);

    // Short reset pulse mid-sequence at state B.
    #4; rst = 1'b1; #1; rst = 1'b0;
    tick();
    run4(0, 6);
    check("pre_rst_data", {28'h0, data4}, 32'hB);
    #2; rst = 1'b1; #1;
    check("mid_rst_data", {28'h0, data4}, 32'h0);
    check("mid_rst_done", {31'h0, done4}, 32'h0);
    #2; rst = 1'b0;
    run4(0, 15);

    // Reset clears a pending seed error pulse.
    dv4 = 1'b1; seed4 = 4'hF;
    tick();
    dv4 = 1'b0;
    check("pulse_serr", {31'h0, serr4}, 32'h1);
    #2; rst = 1'b1; #1;
    check("rst_serr_clr", {31'h0, serr4}, 32'h0);
    #2; rst = 1'b0;
    tick();

    // 8-bit: first steps, then full period.
    en8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("seq8_data", {24'h0, data8}, {24'h0, seq8[k]});
    end
    en8 = 1'b0;
    count8(steps, perr_seen);
    check("p8_steps", steps, 32'd251);
    check("p8_perr", {31'h0, perr_seen}, 32'h0);
    check("p8_data", {24'h0, data8}, 32'h0);
    count8(steps, perr_seen);
    check("p8_steps2", steps, 32'd255);

    // 8-bit: reload after 100 advances, then a full period from the seed.
    en8 = 1'b1;
    perr_seen = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done8 || perr8) perr_seen = 1'b1;
    end
    check("p8_early", {31'h0, perr_seen}, 32'h0);
    en8 = 1'b0; dv8 = 1'b1; seed8 = 8'hA5;
    tick();
    dv8 = 1'b0;
    check("ld8_data", {24'h0, data8}, 32'hA5);
    check("ld8_perr", {31'h0, perr8}, 32'h0);
    count8(steps, perr_seen);
    check("ld8_steps", steps, 32'd255);
    check("ld8_perr_run", {31'h0, perr_seen}, 32'h0);
    check("ld8_end", {24'h0, data8}, 32'hA5);
    check("serr8", {31'h0, serr8}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_engine.md
Name: lfsr_engine

Overview:
Parametrised XNOR-feedback Fibonacci LFSR engine, the successor to the free-running pseudo-random generator. Adds clock enable, runtime seed load with lock-up protection, and a registered end-of-sequence pulse. Used by game logic for random values, test patterns and long-period timers. Single clock domain.

Parameters:
NUM_BITS, 8, register width; legal range 3..32, anything else is an elaboration error.
INIT_SEED, 0, state loaded on reset; must not be all ones, which is an elaboration error.

Ports:
i_Clk  in  1  system clock, all logic rising-edge.
i_Reset  in  1  asynchronous, active-high reset.
i_Enable  in  1  advance LFSR one step on this edge.
i_Seed_DV  in  1  load i_Seed_Data this edge; has priority over i_Enable.
i_Seed_Data  in  NUM_BITS  new state and sequence start point.
o_LFSR_Data  out  NUM_BITS  current LFSR state, registered.
o_LFSR_Done  out  1  one-cycle pulse: sequence returned to start point.
o_Seed_Err  out  1  one-cycle pulse: an all-ones seed was rejected.
o_Period_Err  out  1  period-check failure pulse; tied 0 unless LFSR_PERIOD_CHECK_EN is defined.

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately, including mid-sequence. State and start register = INIT_SEED; o_LFSR_Done, o_Seed_Err and o_Period_Err = 0.
- State r_LFSR[NUM_BITS:1]; o_LFSR_Data = r_LFSR. Start register r_Start holds the last loaded seed.
- Feedback: fb = XNOR-reduction of the tap bits for NUM_BITS, using the maximal-length XNOR tap table, e.g. 4:{4,3}, 5:{5,3}, 8:{8,6,5,4}, 16:{16,15,13,4}, 32:{32,22,2,1}.
- Per-edge priority:
  - i_Seed_DV=1: r_LFSR and r_Start load i_Seed_Data. If i_Seed_Data is all ones (the lock-up state), load all zeros instead and pulse o_Seed_Err the next cycle. o_LFSR_Done is not asserted because of a load.
  - else i_Enable=1: r_LFSR <= {r_LFSR[NUM_BITS-1:1], fb}.
  - else: hold all state.
- Done: register a flag when an enabled advance produces a next state equal to r_Start. o_LFSR_Done is high for exactly the one cycle after that edge.
- Period: with continuous enable, o_LFSR_Done pulses every 2^NUM_BITS-1 cycles. Enable gaps stretch the period in cycles but never in steps.
- Latency: data visible 1 cycle after the enable or load edge. Done and error pulses appear in the same cycle as the data change.
- The all-ones state is unreachable from any legal start. No lock-up recovery logic beyond seed filtering.
- Simultaneous i_Seed_DV and i_Enable: the load wins and no advance occurs.

Optional Feature:
LFSR_PERIOD_CHECK_EN.
- When defined: a NUM_BITS-wide step counter clears on reset, on load and on each done event, and increments on each enabled advance. o_Period_Err pulses for 1 cycle in either case:
  - a done event occurs with counter+1 != 2^NUM_BITS-1;
  - the counter reaches 2^NUM_BITS-1 without a done event.
  On error the counter clears.
- When not defined: no counter is built and o_Period_Err is constant 0.

Decomposition:
- Shared package lfsr_pkg holds:
  - constant function lfsr_taps(N), returning a 32-bit tap mask;
  - constants LFSR_MIN_BITS=3 and LFSR_MAX_BITS=32.
- Natural sub-module: lfsr_feedback, a combinational XNOR reduction of state AND tap mask. It is parametrised by NUM_BITS, with state in and fb out.

Test Plan:
- NUM_BITS=4, INIT_SEED=0, reset, then continuous enable -> o_LFSR_Data = 0,1,3,7,E,D,B,6,C,9,2,5,A,4,8,0. o_LFSR_Done pulses once, in the cycle the data returns to 0 (15th advance), and again 15 cycles later.
- NUM_BITS=4, enable toggled 1/0 each cycle -> same sequence at half rate. Done after 15 advances, i.e. 29-30 cycles; data holds while enable is low.
- Seed load 0x5, then enable -> sequence A,4,8,0,1,... and done when data returns to 5, after 15 advances. Load 0xF -> data 0, r_Start=0, o_Seed_Err pulses 1 cycle.
- i_Seed_DV and i_Enable both high with seed 0x3 -> data=3, no advance, no done.
- Assert i_Reset mid-sequence (data=B) for less than one clock period -> data immediately INIT_SEED and all pulses 0. Sequence restarts and done occurs 15 advances later.
- With LFSR_PERIOD_CHECK_EN, NUM_BITS=8, 255 continuous advances -> done at advance 255, o_Period_Err stays 0. Force a seed reload at advance 100 -> counter clears, no error.
